// File: rtl/parking_pkg.sv
// Shared types and sizing helpers for the parking barrier controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    OPEN   = 3'd2,
    SETUP  = 3'd3,
    PULSE  = 3'd4,
    HOLD   = 3'd5,
    REJECT = 3'd6
  } gate_state_t;

  localparam int CNT_W_DEF         = 11;
  localparam int OPEN_TIMEOUT_DEF  = 30;
  localparam int PULSE_CYCLES_DEF  = 2;
  localparam int REJECT_CYCLES_DEF = 5;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  localparam int TMR_W_DEF = timer_width(OPEN_TIMEOUT_DEF, REJECT_CYCLES_DEF, PULSE_CYCLES_DEF);

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier lane: request check, open window, strobe sequencing and re-arm.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT  = OPEN_TIMEOUT_DEF,
  parameter int PULSE_CYCLES  = PULSE_CYCLES_DEF,
  parameter int REJECT_CYCLES = REJECT_CYCLES_DEF,
  parameter bit HAS_REJECT    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic pass,
  input  logic is_uni,
  input  logic permit,
  output logic open,
  output logic strobe,
  output logic flag,
  output logic reject
);

  localparam int TMR_W = timer_width(OPEN_TIMEOUT, REJECT_CYCLES, PULSE_CYCLES);

  gate_state_t      state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             armed, armed_next;
  logic             flag_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (req && armed) state_next = CHECK;
      CHECK:  if (permit) state_next = OPEN;
              else if (HAS_REJECT) state_next = REJECT;
              else state_next = IDLE;
      OPEN:   if (pass) state_next = SETUP;
              else if (timer == TMR_W'(OPEN_TIMEOUT - 1)) state_next = IDLE;
      SETUP:  state_next = PULSE;
      PULSE:  if (timer == TMR_W'(PULSE_CYCLES - 1)) state_next = HOLD;
      HOLD:   state_next = IDLE;
      REJECT: if (timer == TMR_W'(REJECT_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Timer restarts on every state change and only runs in timed states.
  always_comb begin
    timer_next = '0;
    if (state_next == state && (state == OPEN || state == PULSE || state == REJECT))
      timer_next = timer + 1'b1;
  end

  // A request is consumed when CHECK is entered; only a low req re-arms the lane.
  always_comb begin
    armed_next = armed;
    if (!req) armed_next = 1'b1;
    else if (state_next == CHECK) armed_next = 1'b0;
  end

  always_comb begin
    flag_next = flag;
    if (state == IDLE && state_next == CHECK) flag_next = is_uni;
    else if (state_next == IDLE) flag_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      armed  <= 1'b1;
      flag   <= 1'b0;
      open   <= 1'b0;
      strobe <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= state_next;
      timer  <= timer_next;
      armed  <= armed_next;
      flag   <= flag_next;
      open   <= (state_next == OPEN);
      strobe <= (state_next == PULSE);
      reject <= (state_next == REJECT);
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding the occupancy counter.
// Define PARKING_GATE_REJECT_CNT_EN to add the saturating reject_count output.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT  = OPEN_TIMEOUT_DEF,
  parameter int PULSE_CYCLES  = PULSE_CYCLES_DEF,
  parameter int REJECT_CYCLES = REJECT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    entry_req,
  input  logic                    entry_is_uni,
  input  logic                    entry_pass,
  input  logic                    exit_req,
  input  logic                    exit_is_uni,
  input  logic                    exit_pass,
  input  logic                    uni_is_vacated_space,
  input  logic                    is_vacated_space,
  input  logic signed [CNT_W-1:0] uni_parked_car,
  input  logic signed [CNT_W-1:0] parked_car,
  output logic                    car_entered,
  output logic                    is_uni_car_entered,
  output logic                    car_exited,
  output logic                    is_uni_car_exited,
  output logic                    entry_open,
  output logic                    exit_open,
  output logic                    entry_reject
`ifdef PARKING_GATE_REJECT_CNT_EN
  , output logic [15:0]           reject_count
`endif
);

  logic                    entry_permit;
  logic                    exit_permit;
  logic signed [CNT_W-1:0] exit_cnt;

  assign entry_permit = entry_is_uni ? uni_is_vacated_space : is_vacated_space;
  // The exit category is the latched flag, so a badge change after IDLE cannot flip it.
  assign exit_cnt     = is_uni_car_exited ? uni_parked_car : parked_car;
  assign exit_permit  = (exit_cnt > 0);

  parking_gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .PULSE_CYCLES (PULSE_CYCLES),
    .REJECT_CYCLES(REJECT_CYCLES),
    .HAS_REJECT   (1'b1)
  ) u_entry (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (entry_req),
    .pass  (entry_pass),
    .is_uni(entry_is_uni),
    .permit(entry_permit),
    .open  (entry_open),
    .strobe(car_entered),
    .flag  (is_uni_car_entered),
    .reject(entry_reject)
  );

  logic exit_reject_unused;

  parking_gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .PULSE_CYCLES (PULSE_CYCLES),
    .REJECT_CYCLES(REJECT_CYCLES),
    .HAS_REJECT   (1'b0)
  ) u_exit (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (exit_req),
    .pass  (exit_pass),
    .is_uni(exit_is_uni),
    .permit(exit_permit),
    .open  (exit_open),
    .strobe(car_exited),
    .flag  (is_uni_car_exited),
    .reject(exit_reject_unused)
  );

`ifdef PARKING_GATE_REJECT_CNT_EN
  logic reject_prev;

  // Lamp rising edge marks entry into REJECT; consecutive rejects always pass through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_prev  <= 1'b0;
      reject_count <= 16'd0;
    end else begin
      reject_prev <= entry_reject;
      if (entry_reject && !reject_prev && reject_count != 16'hFFFF)
        reject_count <= reject_count + 16'd1;
    end
  end
`endif

endmodule
